// File: rtl/rv32i_writeback.sv
// RV32I writeback stage: formats load data and drives the registered register-file write port.
// Optional load timeout abort when WB_TIMEOUT_EN is defined (parameter LOAD_TIMEOUT).
module rv32i_writeback #(
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd_addr,
  input  logic        mem_rd_we,
  input  logic        mem_is_load,
  input  logic [2:0]  mem_funct3,
  input  logic [1:0]  mem_addr_lo,
  input  logic [31:0] mem_result,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_we,
  output logic        load_busy,
  output logic [4:0]  load_rd_addr,
  output logic        load_err
);

  typedef enum logic [0:0] {IDLE, WAIT_LOAD} state_t;

  state_t      state, state_nxt;
  logic [4:0]  lat_rd;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [1:0]  lat_lo;
  logic [4:0]  rd_addr_nxt;
  logic [31:0] rd_data_nxt;
  logic        rd_we_nxt;
  logic        load_err_nxt;
  logic        accept;
  logic        timeout;

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    fmt_load = {{24{b[7]}}, b};
      3'd1:    fmt_load = {{16{h[15]}}, h};
      3'd4:    fmt_load = {24'b0, b};
      3'd5:    fmt_load = {16'b0, h};
      default: fmt_load = w;
    endcase
  endfunction

  assign mem_ready    = (state == IDLE);
  assign accept       = mem_valid && mem_ready;
  assign load_busy    = (state == WAIT_LOAD);
  assign load_rd_addr = load_busy ? lat_rd : 5'd0;

`ifdef WB_TIMEOUT_EN
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= 8'd0;
    else if (accept && mem_is_load)
      cnt <= 8'd0;
    else if (state == WAIT_LOAD && !dmem_rvalid)
      cnt <= cnt + 8'd1;
  end

  // Arriving data in the expiry cycle takes priority over the abort.
  assign timeout = (state == WAIT_LOAD) && !dmem_rvalid && (cnt == 8'(LOAD_TIMEOUT));
`else
  logic [7:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 8'(LOAD_TIMEOUT);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_rd <= 5'd0;
      lat_we <= 1'b0;
      lat_f3 <= 3'd0;
      lat_lo <= 2'd0;
    end else if (accept && mem_is_load) begin
      lat_rd <= mem_rd_addr;
      lat_we <= mem_rd_we;
      lat_f3 <= mem_funct3;
      lat_lo <= mem_addr_lo;
    end
  end

  always_comb begin
    state_nxt    = state;
    rd_addr_nxt  = rd_addr;
    rd_data_nxt  = rd_data;
    rd_we_nxt    = 1'b0;
    load_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (mem_is_load) begin
            state_nxt = WAIT_LOAD;
          end else begin
            rd_addr_nxt = mem_rd_addr;
            rd_data_nxt = mem_result;
            rd_we_nxt   = mem_rd_we && (mem_rd_addr != 5'd0);
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          rd_addr_nxt = lat_rd;
          rd_data_nxt = fmt_load(lat_f3, lat_lo, dmem_rdata);
          rd_we_nxt   = lat_we && (lat_rd != 5'd0);
          state_nxt   = IDLE;
        end else if (timeout) begin
          load_err_nxt = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_addr  <= 5'd0;
      rd_data  <= 32'd0;
      rd_we    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_addr  <= rd_addr_nxt;
      rd_data  <= rd_data_nxt;
      rd_we    <= rd_we_nxt;
      load_err <= load_err_nxt;
    end
  end

endmodule

// File: tb/tb_rv32i_writeback.sv
// Self-checking bench for rv32i_writeback with a behavioural load-format model.
module tb_rv32i_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_rd_addr = '0;
  logic        mem_rd_we = 1'b0;
  logic        mem_is_load = 1'b0;
  logic [2:0]  mem_funct3 = '0;
  logic [1:0]  mem_addr_lo = '0;
  logic [31:0] mem_result = '0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_we;
  logic        load_busy;
  logic [4:0]  load_rd_addr;
  logic        load_err;

  int n_pass = 0;
  int n_total = 0;

  rv32i_writeback #(.LOAD_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_rd_addr(mem_rd_addr), .mem_rd_we(mem_rd_we), .mem_is_load(mem_is_load),
    .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo), .mem_result(mem_result),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we),
    .load_busy(load_busy), .load_rd_addr(load_rd_addr), .load_err(load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Architectural load result: pick byte/halfword by shifting, extend by arithmetic.
  function automatic logic [31:0] ref_load(input int f3, input int lo, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (lo >= 2) ? (w >> 16) : (w & 32'hFFFF);
    case (f3)
      0:       return (b >= 128) ? b - 256 : b;
      1:       return (h >= 32768) ? h - 65536 : h;
      4:       return b;
      5:       return h;
      default: return w;
    endcase
  endfunction

  // Drives one load whose data arrives 'delay' cycles after acceptance; reports what was seen.
  task automatic run_load(input logic [4:0] rd, input logic we_q, input logic [2:0] f3,
                          input logic [1:0] lo, input logic [31:0] word, input int delay,
                          output int stall, output logic busy_ok, output logic err_seen,
                          output logic got_we, output logic [4:0] got_addr,
                          output logic [31:0] got_data, output logic post_ok);
    mem_valid = 1'b1; mem_is_load = 1'b1; mem_rd_addr = rd; mem_rd_we = we_q;
    mem_funct3 = f3; mem_addr_lo = lo; mem_result = $urandom;
    tick;
    mem_valid = 1'b0; mem_is_load = 1'b0; mem_rd_addr = 5'($urandom);
    mem_funct3 = 3'($urandom); mem_addr_lo = 2'($urandom); mem_rd_we = 1'($urandom);
    stall = 0; busy_ok = 1'b1; err_seen = 1'b0;
    for (int k = 1; k <= delay; k++) begin
      if (!mem_ready && load_busy) stall++;
      if (load_rd_addr !== rd || rd_we !== 1'b0) busy_ok = 1'b0;
      if (load_err) err_seen = 1'b1;
      if (k == delay) begin dmem_rvalid = 1'b1; dmem_rdata = word; end
      tick;
    end
    dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    got_we = rd_we; got_addr = rd_addr; got_data = rd_data;
    if (load_err) err_seen = 1'b1;
    post_ok = mem_ready && !load_busy && (load_rd_addr == 5'd0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_total++; if (rd_we !== 1'b0) $display("FAIL reset_rd_we got %b want 0", rd_we); else n_pass++;
    n_total++; if (rd_addr !== 5'd0) $display("FAIL reset_rd_addr got %0d want 0", rd_addr); else n_pass++;
    n_total++; if (rd_data !== 32'd0) $display("FAIL reset_rd_data got %h want 0", rd_data); else n_pass++;
    n_total++; if (load_busy !== 1'b0) $display("FAIL reset_load_busy got %b want 0", load_busy); else n_pass++;
    n_total++; if (load_rd_addr !== 5'd0) $display("FAIL reset_load_rd_addr got %0d want 0", load_rd_addr); else n_pass++;
    n_total++; if (load_err !== 1'b0) $display("FAIL reset_load_err got %b want 0", load_err); else n_pass++;
    n_total++; if (mem_ready !== 1'b1) $display("FAIL reset_mem_ready got %b want 1", mem_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1; mem_is_load = 1'b0; mem_rd_we = 1'b1;
      mem_rd_addr = 5'(i + 1); mem_result = vals[i];
      tick;
      n_total++;
      if (rd_we !== 1'b1 || rd_addr !== 5'(i + 1) || rd_data !== vals[i])
        $display("FAIL b2b_write%0d got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                 i, rd_we, rd_addr, rd_data, i + 1, vals[i]);
      else n_pass++;
    end
    mem_valid = 1'b0;
    tick;
    n_total++; if (rd_we !== 1'b0) $display("FAIL b2b_idle got we=%b want 0", rd_we); else n_pass++;
  endtask

  task automatic test_x0;
    mem_valid = 1'b1; mem_is_load = 1'b0; mem_rd_we = 1'b1;
    mem_rd_addr = 5'd0; mem_result = 32'hDEADBEEF;
    tick;
    n_total++; if (rd_we !== 1'b0) $display("FAIL x0_write got we=%b want 0", rd_we); else n_pass++;
    mem_rd_addr = 5'd9; mem_rd_we = 1'b0;
    tick;
    n_total++; if (rd_we !== 1'b0) $display("FAIL no_we_write got we=%b want 0", rd_we); else n_pass++;
    mem_valid = 1'b0;
    tick;
  endtask

  task automatic test_load_format;
    int stall; logic busy_ok, err_seen, got_we, post_ok; logic [4:0] got_addr; logic [31:0] got_data;
    run_load(5'd5, 1'b1, 3'd0, 2'd3, 32'h80FF_0102, 4, stall, busy_ok, err_seen, got_we, got_addr, got_data, post_ok);
    n_total++; if (stall !== 4) $display("FAIL lb_stall got %0d want 4", stall); else n_pass++;
    n_total++; if (busy_ok !== 1'b1) $display("FAIL lb_busy_addr got %b want 1", busy_ok); else n_pass++;
    n_total++;
    if (got_we !== 1'b1 || got_addr !== 5'd5 || got_data !== 32'hFFFF_FF80)
      $display("FAIL lb_write got we=%b addr=%0d data=%h want we=1 addr=5 data=ffffff80", got_we, got_addr, got_data);
    else n_pass++;
    n_total++; if (post_ok !== 1'b1) $display("FAIL lb_ready_after got %b want 1", post_ok); else n_pass++;
    run_load(5'd6, 1'b1, 3'd5, 2'd2, 32'h8001_7FFF, 1, stall, busy_ok, err_seen, got_we, got_addr, got_data, post_ok);
    n_total++; if (got_data !== 32'h0000_8001 || got_we !== 1'b1) $display("FAIL lhu_data got %h we=%b want 00008001 we=1", got_data, got_we); else n_pass++;
    run_load(5'd7, 1'b1, 3'd1, 2'd0, 32'h0000_8000, 2, stall, busy_ok, err_seen, got_we, got_addr, got_data, post_ok);
    n_total++; if (got_data !== 32'hFFFF_8000) $display("FAIL lh_data got %h want ffff8000", got_data); else n_pass++;
    run_load(5'd8, 1'b1, 3'd2, 2'd1, 32'hCAFE_1234, 3, stall, busy_ok, err_seen, got_we, got_addr, got_data, post_ok);
    n_total++; if (got_data !== 32'hCAFE_1234) $display("FAIL lw_data got %h want cafe1234", got_data); else n_pass++;
  endtask

  task automatic test_random;
    int stall, f3, lo, delay; logic busy_ok, err_seen, got_we, post_ok, we_q, exp_we;
    logic [4:0] got_addr, rd; logic [31:0] got_data, word, exp_data;
    for (int i = 0; i < 60; i++) begin
      rd = 5'($urandom); we_q = ($urandom_range(0, 7) != 0); word = $urandom;
      exp_we = we_q && (rd != 5'd0);
      if ($urandom_range(0, 1) == 1) begin
        f3 = $urandom_range(0, 7); lo = $urandom_range(0, 3); delay = $urandom_range(1, 5);
        exp_data = ref_load(f3, lo, word);
        run_load(rd, we_q, 3'(f3), 2'(lo), word, delay, stall, busy_ok, err_seen, got_we, got_addr, got_data, post_ok);
        n_total++;
        if (stall !== delay || busy_ok !== 1'b1 || err_seen !== 1'b0 || post_ok !== 1'b1)
          $display("FAIL rnd_load_ctl%0d got stall=%0d busy=%b err=%b post=%b want %0d 1 0 1",
                   i, stall, busy_ok, err_seen, post_ok, delay);
        else n_pass++;
        n_total++;
        if (got_we !== exp_we || (exp_we && (got_addr !== rd || got_data !== exp_data)))
          $display("FAIL rnd_load%0d f3=%0d lo=%0d got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                   i, f3, lo, got_we, got_addr, got_data, exp_we, rd, exp_data);
        else n_pass++;
      end else begin
        mem_valid = 1'b1; mem_is_load = 1'b0; mem_rd_addr = rd; mem_rd_we = we_q; mem_result = word;
        tick;
        mem_valid = 1'b0;
        n_total++;
        if (rd_we !== exp_we || (exp_we && (rd_addr !== rd || rd_data !== word)))
          $display("FAIL rnd_alu%0d got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                   i, rd_we, rd_addr, rd_data, exp_we, rd, word);
        else n_pass++;
      end
      if ($urandom_range(0, 3) == 0) begin
        mem_valid = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = $urandom;
        tick;
        dmem_rvalid = 1'b0;
        n_total++;
        if (rd_we !== 1'b0 || mem_ready !== 1'b1)
          $display("FAIL rnd_stray%0d got we=%b ready=%b want we=0 ready=1", i, rd_we, mem_ready);
        else n_pass++;
      end
    end
    mem_valid = 1'b0;
    tick;
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout;
    int cyc; logic wrote;
    mem_valid = 1'b1; mem_is_load = 1'b1; mem_rd_addr = 5'd10; mem_rd_we = 1'b1;
    mem_funct3 = 3'd2; mem_addr_lo = 2'd0;
    tick;
    mem_valid = 1'b0; mem_is_load = 1'b0;
    cyc = 1; wrote = 1'b0;
    while (!load_err && cyc < 20) begin
      if (rd_we) wrote = 1'b1;
      tick; cyc++;
    end
    n_total++; if (cyc !== 6) $display("FAIL timeout_cycle got %0d want 6", cyc); else n_pass++;
    n_total++;
    if (wrote !== 1'b0 || rd_we !== 1'b0 || mem_ready !== 1'b1 || load_busy !== 1'b0)
      $display("FAIL timeout_state got wrote=%b we=%b ready=%b busy=%b want 0 0 1 0", wrote, rd_we, mem_ready, load_busy);
    else n_pass++;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    tick;
    dmem_rvalid = 1'b0;
    n_total++;
    if (load_err !== 1'b0 || rd_we !== 1'b0)
      $display("FAIL timeout_after got err=%b we=%b want 0 0", load_err, rd_we);
    else n_pass++;
    tick;
  endtask
`else
  task automatic test_timeout;
    int stall; logic busy_ok, err_seen, got_we, post_ok; logic [4:0] got_addr; logic [31:0] got_data;
    run_load(5'd10, 1'b1, 3'd2, 2'd0, 32'h1357_9BDF, 20, stall, busy_ok, err_seen, got_we, got_addr, got_data, post_ok);
    n_total++;
    if (stall !== 20 || err_seen !== 1'b0)
      $display("FAIL long_wait_ctl got stall=%0d err=%b want 20 0", stall, err_seen);
    else n_pass++;
    n_total++;
    if (got_we !== 1'b1 || got_addr !== 5'd10 || got_data !== 32'h1357_9BDF)
      $display("FAIL long_wait_write got we=%b addr=%0d data=%h want 1 10 13579bdf", got_we, got_addr, got_data);
    else n_pass++;
  endtask
`endif

  task automatic test_reset_mid_load;
    mem_valid = 1'b1; mem_is_load = 1'b1; mem_rd_addr = 5'd12; mem_rd_we = 1'b1;
    mem_funct3 = 3'd2; mem_addr_lo = 2'd0;
    tick;
    mem_valid = 1'b0; mem_is_load = 1'b0;
    tick;
    n_total++; if (load_busy !== 1'b1) $display("FAIL midrst_busy got %b want 1", load_busy); else n_pass++;
    rst_n = 1'b0;
    #2;
    n_total++;
    if (load_busy !== 1'b0 || rd_data !== 32'd0 || mem_ready !== 1'b1)
      $display("FAIL midrst_async got busy=%b data=%h ready=%b want 0 0 1", load_busy, rd_data, mem_ready);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hA5A5_A5A5;
    tick;
    dmem_rvalid = 1'b0;
    n_total++;
    if (rd_we !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0 || load_busy !== 1'b0 ||
        load_rd_addr !== 5'd0 || load_err !== 1'b0 || mem_ready !== 1'b1)
      $display("FAIL midrst_late_rvalid got we=%b addr=%0d data=%h busy=%b lrd=%0d err=%b ready=%b",
               rd_we, rd_addr, rd_data, load_busy, load_rd_addr, load_err, mem_ready);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_x0;
    test_load_format;
    test_random;
    test_timeout;
    test_reset_mid_load;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
